// File: rtl/sensor_conditioner.sv
// Loop-sensor/button conditioner: 2-flop sync, per-bit debounce, queue-density and request decode.
// Latency: raw level reaches veh_* DEBOUNCE+2 edges after first sample; no backpressure, ss_req held until ss_ack.
module sensor_conditioner #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 3
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [2:0] raw_a,
  input  logic [2:0] raw_b,
  input  logic [2:0] raw_c,
  input  logic [2:0] raw_d,
  input  logic [3:0] raw_ss,
  input  logic [3:0] ss_ack,
  output logic [2:0] veh_a,
  output logic [2:0] veh_b,
  output logic [2:0] veh_c,
  output logic [2:0] veh_d,
  output logic [1:0] level_a,
  output logic [1:0] level_b,
  output logic [1:0] level_c,
  output logic [1:0] level_d,
  output logic [3:0] ss_req,
  output logic       ss_any,
  output logic [1:0] ss_sel,
  output logic [2:0] busiest,
  output logic [3:0] sens_err
);

  localparam int NB = 16;

  logic [NB-1:0]    raw_all;
  logic [NB-1:0]    sync1;
  logic [NB-1:0]    sync2;
  logic [NB-1:0]    filt;
  logic [CNT_W-1:0] cnt [NB];
  logic [3:0]       ss_filt;
  logic [3:0]       ss_prev;
  logic [3:0]       ss_rise;
  logic [1:0]       lv [4];
  logic [1:0]       best_lvl;
  logic [1:0]       best_idx;

  assign raw_all = {raw_ss, raw_d, raw_c, raw_b, raw_a};

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_all;
      sync2 <= sync1;
    end
  end

  // A bit only flips after DEBOUNCE consecutive cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      filt <= '0;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DEBOUNCE - 1)) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign veh_a   = filt[2:0];
  assign veh_b   = filt[5:3];
  assign veh_c   = filt[8:6];
  assign veh_d   = filt[11:9];
  assign ss_filt = filt[15:12];

  assign ss_rise = ss_filt & ~ss_prev;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      ss_prev <= '0;
      ss_req  <= '0;
    end else begin
      ss_prev <= ss_filt;
      ss_req  <= (ss_req & ~ss_ack) | ss_rise;
    end
  end

  // Highest set bit decides the level, so a broken thermometer still reports its farthest occupied loop.
  function automatic logic [1:0] level_of(input logic [2:0] v);
    if (v[2])      return 2'd3;
    else if (v[1]) return 2'd2;
    else if (v[0]) return 2'd1;
    else           return 2'd0;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_appr
    logic [2:0] v;
    assign v           = filt[3*g +: 3];
    assign lv[g]       = level_of(v);
    assign sens_err[g] = !((v == 3'b000) || (v == 3'b001) || (v == 3'b011) || (v == 3'b111));
  end

  assign level_a = lv[0];
  assign level_b = lv[1];
  assign level_c = lv[2];
  assign level_d = lv[3];

  always_comb begin
    best_lvl = lv[0];
    best_idx = 2'd0;
    for (int j = 1; j < 4; j++) begin
      if (lv[j] > best_lvl) begin
        best_lvl = lv[j];
        best_idx = 2'(j);
      end
    end
    busiest = (best_lvl == 2'd0) ? 3'b100 : {1'b0, best_idx};
  end

  assign ss_any = |ss_req;

  always_comb begin
    ss_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (ss_req[i]) ss_sel = 2'(i);
    end
  end

endmodule

// File: doc/sensor_conditioner.md
SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 The block SHALL accept parameters, one per line (name, default, meaning):
  DEBOUNCE  4  consecutive stable synchronized cycles required before a filtered bit changes; legal range 2..7
  CNT_W     3  debounce counter width
REQ-002 The block SHALL provide these ports, one per line (name  direction  width  meaning):
  clock     input   1  single clock; all state updates on its rising edge
  clear     input   1  asynchronous, active-low reset
  raw_a     input   3  approach A loop sensors, bit0 nearest stop line (raw, asynchronous)
  raw_b     input   3  approach B loop sensors
  raw_c     input   3  approach C loop sensors
  raw_d     input   3  approach D loop sensors
  raw_ss    input   4  special-service/emergency request buttons, bit i = approach i (raw)
  ss_ack    input   4  controller acknowledge, bit i clears pending request i
  veh_a..veh_d  output  3 each  debounced sensor bits, fed to the traffic controller a1..d3
  level_a..level_d  output  2 each  queue density 0..3 per approach
  ss_req    output  4  sticky pending special-service requests
  ss_any    output  1  OR of ss_req
  ss_sel    output  2  index of highest-priority pending request
  busiest   output  3  densest approach; 3'b100 = no vehicles
  sens_err  output  4  bit i high = approach i sensor pattern not thermometer

Function
REQ-003 Every raw bit (16 total) SHALL pass through a two-flop synchronizer before any other logic uses it.
REQ-004 Each synchronized bit SHALL have its own filtered register and CNT_W-bit counter.
REQ-005 Cycle where synchronized value equals filtered value: counter SHALL reset to 0.
REQ-006 Cycle where they differ: counter SHALL increment; when the counter is already DEBOUNCE-1, the filtered bit SHALL take the synchronized value and the counter SHALL return to 0.
REQ-007 A raw level held stable SHALL reach the filtered output exactly DEBOUNCE+2 rising edges after the first edge that samples it; a synchronized pulse shorter than DEBOUNCE cycles SHALL never change the filtered output.
REQ-008 veh_a..veh_d SHALL be the filtered registers directly; no combinational path from any raw input to any output is permitted.
REQ-009 level_x SHALL decode filtered bits: 000->0, 001->1, 011->2, 111->3; any other pattern SHALL give level = (index of highest set bit)+1 and assert sens_err bit x.
REQ-010 busiest SHALL be {1'b0, idx} of the approach with the greatest level, ties to the lowest index (A=0 .. D=3); all levels 0 SHALL give 3'b100.
REQ-011 ss_req[i] SHALL set on the cycle after filtered raw_ss[i] rises 0->1 (edge detect on filtered value, one set per press).
REQ-012 ss_req[i] SHALL clear on the edge where ss_ack[i] is high; set and ack in the same cycle SHALL leave ss_req[i] = 1 (new press wins).
REQ-013 ss_ack[i] while ss_req[i] = 0 SHALL have no effect; holding a button SHALL not re-set after acknowledge until released and pressed again.
REQ-014 ss_sel SHALL be the lowest index i with ss_req[i] = 1, and 0 when ss_any = 0.
REQ-015 level, busiest, sens_err, ss_any, ss_sel SHALL be pure decodes of registered state and SHALL update in the same cycle as that state.

Reset
REQ-016 clear low SHALL immediately force all synchronizer flops, filtered registers, counters, edge-detect flops and ss_req to 0, abandoning any partial debounce count.
REQ-017 Output values under reset: veh_* 0, level_* 0, ss_req 0, ss_any 0, ss_sel 0, busiest 3'b100, sens_err 0.
REQ-018 After clear rises, the first rising edge SHALL begin sampling; a raw input already high SHALL appear on the filtered output DEBOUNCE+2 edges later.

Verification
REQ-019 raw_b = 3'b011 held from edge 0 (DEBOUNCE=4) -> veh_b = 011 and level_b = 2 at edge 6, busiest = 3'b001 at edge 6, 3'b100 before.
REQ-020 raw_a[0] pulse of 3 cycles -> veh_a stays 000, busiest stays 3'b100 throughout.
REQ-021 raw_a = 111, raw_c = 111 stable -> level_a = level_c = 3, busiest = 3'b000 (tie to lowest index).
REQ-022 raw_d = 101 stable -> level_d = 3, sens_err = 4'b1000.
REQ-023 press raw_ss[2] then raw_ss[1] -> ss_req = 0100 then 0110, ss_sel = 2 then 1; ss_ack = 0010 -> ss_req = 0100, ss_sel = 2; ack and new press of bit 2 in same cycle -> ss_req[2] stays 1.
REQ-024 clear pulsed low mid-debounce with raw_c = 111 held -> all outputs at reset values immediately; veh_c = 111 exactly 6 edges after clear rises.
